// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and constants for the data-memory responder
// Contents: BIN_DIG data width, RV32I load/store width codes, FSM state enum,
// registered response struct.
package dmem_responder_pkg;

  localparam int BIN_DIG = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [BIN_DIG-1:0] rdata;
    logic               err;
  } rsp_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between memory stage and data memory
// Signals: req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata (request),
// rsp_valid/rsp_ready/rsp_rdata/rsp_err (response).
// Modports: master = requester (memory-access stage), slave = responder.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [2:0]         req_funct3;
  logic [BIN_DIG-1:0] req_addr;
  logic [BIN_DIG-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [BIN_DIG-1:0] rsp_rdata;
  logic               rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - byte-lane enables, store lane placement, load extraction/extension
// Ports: funct3/addr_lo (access width and byte offset), wdata (store data, low-aligned),
// rword (addressed memory word), be (byte enables), wlanes (store data in lane position),
// rdata (extended load result), misalign (misaligned access flag).
// Macro DMEM_MISALIGN_CHECK_EN: when defined, misaligned H/HU/W raise misalign;
// otherwise the low address bits below the access size are ignored.
module dmem_lane_unit
  import dmem_responder_pkg::*;
(
  input  logic [2:0]         funct3,
  input  logic [1:0]         addr_lo,
  input  logic [BIN_DIG-1:0] wdata,
  input  logic [BIN_DIG-1:0] rword,
  output logic [3:0]         be,
  output logic [BIN_DIG-1:0] wlanes,
  output logic [BIN_DIG-1:0] rdata,
  output logic               misalign
);

  logic [1:0]         off;
  logic [BIN_DIG-1:0] sh;

  always_comb begin
    off      = addr_lo;
    be       = 4'b0000;
    misalign = 1'b0;
    rdata    = '0;
    // Halfwords snap to the even lane pair and words to lane 0, so an
    // unchecked misaligned access still touches whole aligned lanes.
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: begin
        off = {addr_lo[1], 1'b0};
        be  = 4'b0011 << off;
      end
      F3_W: begin
        off = 2'b00;
        be  = 4'b1111;
      end
      default: be = 4'b0000;
    endcase
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) ||
               ((funct3 == F3_W) && (addr_lo != 2'b00));
`endif
    wlanes = wdata << {off, 3'b000};
    sh     = rword >> {off, 3'b000};
    case (funct3)
      F3_B:    rdata = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   rdata = {24'd0, sh[7:0]};
      F3_H:    rdata = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   rdata = {16'd0, sh[15:0]};
      F3_W:    rdata = rword;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding RV32I data-memory responder with fixed latency
// Parameters: MEM_WORDS (32-bit words in the array), LATENCY (edges from accept to rsp_valid, >=1).
// Ports: clk, rst_n (async active-low), bus (dmem_responder_if.slave: request and response channels).
// Macro DMEM_MISALIGN_CHECK_EN: enables misaligned H/HU/W rejection in dmem_lane_unit.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [BIN_DIG-1:0] mem [MEM_WORDS];

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  rsp_t               rsp, rsp_nxt;

  logic               idle;
  logic               accept;
  logic               in_range;
  logic               f3_bad;
  logic               err;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         be;
  logic [BIN_DIG-1:0] wlanes;
  logic [BIN_DIG-1:0] ld_data;
  logic               misalign;

  assign idle     = (state == IDLE);
  assign accept   = bus.req_valid && idle;
  assign idx      = bus.req_addr[IDX_W+1:2];
  assign in_range = {2'b00, bus.req_addr[31:2]} < 32'(MEM_WORDS);
  assign f3_bad   = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                    (bus.req_funct3 == 3'b111);
  // Unsigned widths only exist for loads.
  assign err      = !in_range || f3_bad || (bus.req_we && bus.req_funct3[2]) || misalign;

  dmem_lane_unit u_lane (
    .funct3   (bus.req_funct3),
    .addr_lo  (bus.req_addr[1:0]),
    .wdata    (bus.req_wdata),
    .rword    (mem[idx]),
    .be       (be),
    .wlanes   (wlanes),
    .rdata    (ld_data),
    .misalign (misalign)
  );

  // Array is deliberately outside reset: committed stores survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !err) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wlanes[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rsp   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rsp   <= rsp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rsp_nxt   = rsp;
    case (state)
      IDLE: begin
        if (accept) begin
          // Load data is captured now so later stores cannot disturb it.
          rsp_nxt.err   = err;
          rsp_nxt.rdata = (err || bus.req_we) ? '0 : ld_data;
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready = idle;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp.rdata;
  assign bus.rsp_err   = rsp.err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (LATENCY=1 and LATENCY=3 instances)
// Expected responses are queued at issue time and checked by per-instance monitors.
// Expectations follow DMEM_MISALIGN_CHECK_EN when it is defined for the build.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  rsp_t q_a[$];
  rsp_t q_b[$];

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();

  dmem_responder #(.MEM_WORDS(16), .LATENCY(1)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa.slave)
  );
  dmem_responder #(.MEM_WORDS(16), .LATENCY(3)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && ifa.rsp_valid && ifa.rsp_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        chk("a_rdata", ifa.rsp_rdata, e.rdata);
        chk("a_err", {31'd0, ifa.rsp_err}, {31'd0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && ifb.rsp_valid && ifb.rsp_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        chk("b_rdata", ifb.rsp_rdata, e.rdata);
        chk("b_err", {31'd0, ifb.rsp_err}, {31'd0, e.err});
      end
    end
  end

  function automatic logic rdy(input int s);
    return (s == 0) ? ifa.req_ready : ifb.req_ready;
  endfunction

  task automatic drive(input int s, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (s == 0) begin
      ifa.req_valid = v; ifa.req_we = we; ifa.req_funct3 = f3;
      ifa.req_addr = addr; ifa.req_wdata = wdata;
    end else begin
      ifb.req_valid = v; ifb.req_we = we; ifb.req_funct3 = f3;
      ifb.req_addr = addr; ifb.req_wdata = wdata;
    end
  endtask

  // Issue one request, queue its expected response, wait for it to drain.
  task automatic req(input int s, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    rsp_t e;
    int   n;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    @(posedge clk); #1;
    drive(s, 1'b1, we, f3, addr, wdata);
    if (s == 0) q_a.push_back(e); else q_b.push_back(e);
    n = 0;
    @(negedge clk);
    while (!rdy(s) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    drive(s, 1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    @(negedge clk);
    while (!rdy(s) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("rsp_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    ifa.rsp_ready = 1'b1;
    ifb.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_req_ready", {31'd0, ifa.req_ready}, 32'd1);
    chk("rst_a_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd0);
    chk("rst_a_rdata", ifa.rsp_rdata, 32'd0);
    chk("rst_a_err", {31'd0, ifa.rsp_err}, 32'd0);
    chk("rst_b_req_ready", {31'd0, ifb.req_ready}, 32'd1);
    chk("rst_b_rsp_valid", {31'd0, ifb.rsp_valid}, 32'd0);
    rst_n = 1'b1;

    // Lane writes and extended reads on the LATENCY=1 instance.
    req(0, 1, F3_W,  32'h10, 32'hDEAD_BEEF, 32'h0, 0);
    req(0, 0, F3_W,  32'h10, 32'h0, 32'hDEAD_BEEF, 0);
    req(0, 1, F3_B,  32'h13, 32'hAAAA_AA80, 32'h0, 0);
    req(0, 0, F3_B,  32'h13, 32'h0, 32'hFFFF_FF80, 0);
    req(0, 0, F3_BU, 32'h13, 32'h0, 32'h0000_0080, 0);
    req(0, 0, F3_W,  32'h10, 32'h0, 32'h80AD_BEEF, 0);
    req(0, 0, F3_H,  32'h12, 32'h0, 32'hFFFF_80AD, 0);
    req(0, 0, F3_HU, 32'h12, 32'h0, 32'h0000_80AD, 0);
    req(0, 0, F3_B,  32'h10, 32'h0, 32'hFFFF_FFEF, 0);
    req(0, 0, F3_B,  32'h11, 32'h0, 32'hFFFF_FFBE, 0);
    req(0, 0, F3_BU, 32'h12, 32'h0, 32'h0000_00AD, 0);
    req(0, 0, F3_H,  32'h11, 32'h0, MIS ? 32'h0 : 32'hFFFF_BEEF, MIS);
    req(0, 0, F3_W,  32'h12, 32'h0, MIS ? 32'h0 : 32'h80AD_BEEF, MIS);
    req(0, 1, F3_H,  32'h16, 32'h1234_5678, 32'h0, 0);
    req(0, 1, F3_B,  32'h14, 32'h0000_0011, 32'h0, 0);
    req(0, 1, F3_B,  32'h15, 32'h0000_0022, 32'h0, 0);
    req(0, 0, F3_W,  32'h14, 32'h0, 32'h5678_2211, 0);
    req(0, 0, F3_HU, 32'h14, 32'h0, 32'h0000_2211, 0);
    req(0, 0, F3_H,  32'h16, 32'h0, 32'h0000_5678, 0);

    // Errors: out of range, illegal codes, unsigned store; no side effects.
    req(0, 1, F3_W,  32'h00, 32'h1111_1111, 32'h0, 0);
    req(0, 1, F3_W,  32'h3C, 32'h3333_3333, 32'h0, 0);
    req(0, 1, F3_W,  32'h40, 32'h0BAD_F00D, 32'h0, 1);
    req(0, 1, 3'b100, 32'h00, 32'h0000_00FF, 32'h0, 1);
    req(0, 1, 3'b101, 32'h3C, 32'h0000_FFFF, 32'h0, 1);
    req(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
    req(0, 0, 3'b110, 32'h10, 32'h0, 32'h0, 1);
    req(0, 0, 3'b111, 32'h10, 32'h0, 32'h0, 1);
    req(0, 0, F3_W,  32'hFFFF_FFF0, 32'h0, 32'h0, 1);
    req(0, 0, F3_W,  32'h00, 32'h0, 32'h1111_1111, 0);
    req(0, 0, F3_W,  32'h3C, 32'h0, 32'h3333_3333, 0);

    // LATENCY=3 timing with response backpressure.
    req(1, 1, F3_W,  32'h08, 32'hCAFE_F00D, 32'h0, 0);
    @(posedge clk); #1;
    ifb.rsp_ready = 1'b0;
    drive(1, 1'b1, 1'b0, F3_W, 32'h08, 32'h0);
    q_b.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    @(negedge clk);
    chk("lat_ready_before", {31'd0, ifb.req_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int e = 1; e <= 3; e++) begin
      if (e > 1) @(posedge clk);
      @(negedge clk);
      chk($sformatf("lat_valid_edge%0d", e), {31'd0, ifb.rsp_valid}, (e == 3) ? 32'd1 : 32'd0);
      chk($sformatf("lat_ready_edge%0d", e), {31'd0, ifb.req_ready}, 32'd0);
    end
    held = ifb.rsp_rdata;
    chk("lat_rdata", held, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, ifb.rsp_valid}, 32'd1);
      chk("hold_ready", {31'd0, ifb.req_ready}, 32'd0);
      chk("hold_rdata", ifb.rsp_rdata, 32'hCAFE_F00D);
    end
    @(posedge clk); #1;
    ifb.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_ready", {31'd0, ifb.req_ready}, 32'd1);
    chk("release_valid", {31'd0, ifb.rsp_valid}, 32'd0);

    // Reset while a committed store's response is still pending.
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, F3_W, 32'h0C, 32'h1234_5678);
    @(negedge clk);
    chk("rst_store_ready", {31'd0, ifb.req_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("in_wait_ready", {31'd0, ifb.req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, ifb.rsp_valid}, 32'd0);
    chk("midrst_ready", {31'd0, ifb.req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_valid_held", {31'd0, ifb.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    req(1, 0, F3_W,  32'h0C, 32'h0, 32'h1234_5678, 0);
    req(1, 0, F3_HU, 32'h0E, 32'h0, 32'h0000_1234, 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("q_a_drained", q_a.size(), 32'd0);
    chk("q_b_drained", q_b.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
